// File: rtl/hs_rx_fifo_pkg.sv
// Shared types and helpers for the SEND/ACK receive FIFO and its synchroniser.
package hs_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;

  // Index width for a DEPTH-entry memory; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hs_rx_fifo_if.sv
// SEND/ACK sender side plus valid/ready consumer side of the receive FIFO.
interface hs_rx_fifo_if
  import hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              in_send;
  logic [DATA_W-1:0] in_data;
  logic              out_ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              in_ready;

  modport master (
    output in_send, in_data, in_ready,
    input  out_ack, out_valid, out_data
  );

  modport slave (
    input  in_send, in_data, in_ready,
    output out_ack, out_valid, out_data
  );
endinterface

// File: rtl/hs_rx_fifo_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module hs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/hs_rx_fifo.sv
// Four-phase SEND/ACK receiver that buffers captured words in a FIFO and
// presents them to local logic over valid/ready.
module hs_rx_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  hs_rx_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_timeout
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              send_s;
  logic              push;
  logic              pop;

  hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.in_send),
    .q   (send_s)
  );

  // Push decision uses the pre-pop level, so a full FIFO delays capture by one
  // cycle after the pop that frees a slot.
  assign push = (state == IDLE) && send_s && (level != DEPTH_L);
  assign pop  = (level != '0) && bus.in_ready;

  assign bus.out_valid = (level != '0);
  assign bus.out_data  = mem[rd_ptr];

  // Storage carries no reset; contents are qualified by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus.out_ack <= 1'b0;
      cnt         <= '0;
      err_timeout <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      case (state)
        IDLE: begin
          if (push) begin
            bus.out_ack <= 1'b1;
            cnt         <= '0;
            state       <= ACKED;
          end
        end
        ACKED: begin
          if (cnt != TIMEOUT_L) cnt <= cnt + 1'b1;
          if (!send_s) begin
            bus.out_ack <= 1'b0;
            state       <= IDLE;
          end else if ((TIMEOUT != 0) &&
                       ((cnt + 1'b1 == TIMEOUT_L) || (cnt == TIMEOUT_L))) begin
            err_timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hs_rx_fifo.sv
// Bench for hs_rx_fifo: vector table, directed corner sequences, and a
// randomized sender/consumer run against a queue reference model.
module tb_hs_rx_fifo;
  logic       clk;
  logic       rst_n;
  logic [2:0] level;
  logic       err_timeout;

  hs_rx_fifo_if #(.DATA_W(32)) bus ();

  hs_rx_fifo #(
    .DATA_W(32), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .bus         (bus),
    .level       (level),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic        send;
    logic [31:0] data;
    logic        ready;
    logic        ack;
    logic        valid;
    logic [2:0]  lvl;
    logic        err;
    logic        dchk;
    logic [31:0] dout;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic r, input logic s, input logic [31:0] d,
                              input logic rdy, input logic a, input logic v,
                              input logic [2:0] l, input logic e,
                              input logic dc, input logic [31:0] dv);
    vec_t x;
    x.rst = r; x.send = s; x.data = d; x.ready = rdy; x.ack = a; x.valid = v;
    x.lvl = l; x.err = e; x.dchk = dc; x.dout = dv;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic wait_ack(input logic want, input string nm);
    int n;
    n = 0;
    while (bus.out_ack !== want && n < 30) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.out_ack), 32'(want));
  endtask

  task automatic hs(input logic [31:0] d);
    bus.in_data = d;
    bus.in_send = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    bus.in_send = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  logic [31:0] q[$];
  logic [31:0] rec[10];
  logic [31:0] pend;
  logic [2:0]  mx;
  logic        prev_ack;
  int          got;
  int          snd_st;

  initial begin
    rst_n       = 1'b0;
    bus.in_send = 1'b0;
    bus.in_data = '0;
    bus.in_ready = 1'b0;

    // rst, send, data, ready | ack, valid, level, err, data-check, data
    for (int i = 0; i < 5; i++)
      vt[i] = mk(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vt[5]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vt[6]  = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vt[7]  = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vt[8]  = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 32'hDEADBEEF);
    vt[9]  = mk(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0);
    vt[10] = mk(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0);
    vt[11] = mk(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 32'hDEADBEEF);
    vt[12] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    vt[13] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);

    #1;
    for (int i = 0; i < 14; i++) begin
      rst_n        = vt[i].rst;
      bus.in_send  = vt[i].send;
      bus.in_data  = vt[i].data;
      bus.in_ready = vt[i].ready;
      tick();
      chk($sformatf("vec%0d_ack", i),   32'(bus.out_ack),   32'(vt[i].ack));
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].valid));
      chk($sformatf("vec%0d_level", i), 32'(level),         32'(vt[i].lvl));
      chk($sformatf("vec%0d_err", i),   32'(err_timeout),   32'(vt[i].err));
      if (vt[i].dchk) chk($sformatf("vec%0d_data", i), bus.out_data, vt[i].dout);
    end

    // Fill to DEPTH, then a fifth word is held off until one pop frees a slot.
    bus.in_ready = 1'b0;
    for (int k = 1; k <= 4; k++) hs(32'(k));
    chk("fill_level", 32'(level), 32'd4);
    bus.in_data = 32'd5;
    bus.in_send = 1'b1;
    repeat (8) tick();
    chk("bp_ack_held", 32'(bus.out_ack), 32'd0);
    chk("bp_level", 32'(level), 32'd4);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    chk("bp_pop_level", 32'(level), 32'd3);
    chk("bp_head", bus.out_data, 32'd2);
    tick();
    chk("bp_ack_rise", 32'(bus.out_ack), 32'd1);
    chk("bp_refill", 32'(level), 32'd4);
    bus.in_send = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    bus.in_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("bp_pop%0d", k), bus.out_data, 32'(k));
      tick();
    end
    bus.in_ready = 1'b0;
    chk("bp_empty", 32'(level), 32'd0);

    // Stream through the pointer wrap with the consumer always ready.
    got = 0;
    mx  = '0;
    fork
      begin
        bus.in_ready = 1'b1;
        for (int w = 0; w < 10; w++) hs(32'h10 + 32'(w));
      end
      begin
        int n;
        n = 0;
        while (got < 10 && n < 500) begin
          @(negedge clk);
          if (level > mx) mx = level;
          if (bus.out_valid && bus.in_ready) begin
            rec[got] = bus.out_data;
            got++;
          end
          n++;
        end
      end
    join
    tick();
    bus.in_ready = 1'b0;
    chk("wrap_count", 32'(got), 32'd10);
    for (int i = 0; i < got; i++) chk($sformatf("wrap_word%0d", i), rec[i], 32'h10 + 32'(i));
    chk("wrap_maxlvl_le2", 32'(mx <= 3'd2), 32'd1);
    chk("wrap_empty", 32'(level), 32'd0);

    // Hold SEND high past the ACK to trip the timeout flag.
    bus.in_data = 32'hA5;
    bus.in_send = 1'b1;
    wait_ack(1'b1, "to_ack");
    repeat (7) tick();
    chk("to_not_yet", 32'(err_timeout), 32'd0);
    tick();
    chk("to_set", 32'(err_timeout), 32'd1);
    bus.in_send = 1'b0;
    wait_ack(1'b0, "to_ack_fall");
    chk("to_sticky", 32'(err_timeout), 32'd1);
    bus.in_ready = 1'b1;
    tick();
    bus.in_ready = 1'b0;
    chk("to_popped", 32'(level), 32'd0);
    chk("to_still_set", 32'(err_timeout), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("to_cleared", 32'(err_timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a handshake with two words held.
    hs(32'h77);
    bus.in_data = 32'h88;
    bus.in_send = 1'b1;
    wait_ack(1'b1, "mid_ack");
    chk("mid_level", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    bus.in_send = 1'b0;
    #1;
    chk("mid_ack_drop", 32'(bus.out_ack), 32'd0);
    chk("mid_level_clr", 32'(level), 32'd0);
    chk("mid_valid_clr", 32'(bus.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized sender and consumer against an in-order queue model.
    q.delete();
    snd_st = 0;
    pend   = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.in_ready = (cyc >= 700) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (bus.out_valid && bus.in_ready) begin
        if (q.size() == 0) chk("rnd_pop_empty_model", 32'(q.size()), 32'd1);
        else chk("rnd_data", bus.out_data, q.pop_front());
      end
      prev_ack = bus.out_ack;
      tick();
      if (bus.out_ack && !prev_ack) begin
        chk("rnd_ack_while_sending", 32'(snd_st), 32'd1);
        q.push_back(pend);
      end
      case (snd_st)
        0: if (cyc < 650 && ($urandom_range(0, 2) == 0)) begin
             pend        = $urandom;
             bus.in_data = pend;
             bus.in_send = 1'b1;
             snd_st      = 1;
           end
        1: if (bus.out_ack) begin
             bus.in_send = 1'b0;
             snd_st      = 2;
           end
        default: if (!bus.out_ack) snd_st = 0;
      endcase
      chk("rnd_level", 32'(level), 32'(q.size()));
      chk("rnd_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    end
    bus.in_ready = 1'b0;
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_no_timeout", 32'(err_timeout), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hs_rx_fifo.md
Name: hs_rx_fifo

Overview:
- Peripheral-side receiver for the SEND/ACK four-phase handshake, generalised from the single-word peripheral FSM.
- Synchronises the sender's SEND into the local clock domain and captures DATA_W-bit words into a DEPTH-entry FIFO.
- Returns ACK to the sender and presents captured words to local logic via valid/ready.
- Adds the behaviour the single-word FSM lacks: buffering, backpressure (ACK withheld while full), a configurable synchroniser depth, and a handshake-timeout error flag.

Parameters:
- DATA_W, 32, width of the SEND-side data bus and of FIFO entries.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flops in the SEND synchroniser chain; minimum 2.
- TIMEOUT, 255, clk cycles in ACKED without SEND falling before err_timeout sets; 0 disables the check.

Ports:
- clk  in  1  single clock for all state.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronous to clk by system design).
- in_send  in  1  SEND from sender, asynchronous to clk.
- in_data  in  DATA_W  sender data; stable while in_send=1 and until out_ack is seen high.
- out_ack  out  1  ACK to sender, registered.
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_W  FIFO head word; meaningful only when out_valid=1.
- in_ready  in  1  consumer pop; a pop occurs when out_valid & in_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- err_timeout  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchroniser flops cleared; FSM in IDLE.
  - out_ack=0, level=0, out_valid=0, err_timeout=0.
  - Read and write pointers = 0; timeout counter = 0.
  - out_data is don't-care during reset.
  - Reset asserted mid-handshake drops out_ack at once and discards FIFO contents. The sender must also be reset.
- Synchroniser: send_s is in_send delayed through SYNC_STAGES flops. Only send_s is used by the FSM; in_data is never synchronised and is sampled directly.
- FSM states:
  - IDLE:
    - If send_s=1 and level<DEPTH: write in_data to mem[wr_ptr], increment wr_ptr (wraps modulo DEPTH), out_ack<=1, go to ACKED, clear the timeout counter.
    - If send_s=1 and level==DEPTH: hold in IDLE with out_ack=0 (backpressure). The sender stalls with SEND high; capture happens on the first cycle level<DEPTH, including the cycle after a pop.
  - ACKED:
    - out_ack held at 1; the timeout counter increments and saturates.
    - If send_s=0: out_ack<=0, go to IDLE.
    - If the counter reaches TIMEOUT while send_s=1: err_timeout<=1 (sticky until reset). FSM stays in ACKED; no other effect.
- Latency: an in_send rise edge followed by SYNC_STAGES clk edges makes send_s=1. out_ack rises on the next edge, i.e. edge SYNC_STAGES+1. out_ack falls SYNC_STAGES+1 edges after in_send falls.
- At most one word is captured per handshake. There is no second write until send_s has been seen low.
- FIFO read side:
  - out_valid = (level!=0).
  - out_data = mem[rd_ptr], combinational from storage.
  - A pop increments rd_ptr (wraps modulo DEPTH).
  - in_ready while empty is ignored; there is no underflow.
- Simultaneous push and pop: level unchanged, both pointers advance. The push decision uses the pre-pop level; a push blocked at full proceeds on the following cycle.
- level is updated as +1 on push only, -1 on pop only, unchanged for both or neither. It never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared package hs_pkg:
  - FSM state typedef (IDLE, ACKED).
  - Default DATA_W constant = 32.
  - Function returning the pointer width from DEPTH.
- One natural sub-module: hs_sync, a SYNC_STAGES-deep single-bit synchroniser with asynchronous active-low reset. It is reused by the CPU-side sender for ACK.

Test Plan:
- Reset hold: rst=0 for 5 cycles with in_send=1 -> out_ack=0, level=0, out_valid=0, err_timeout=0 throughout.
- Single transfer:
  - Stimulus: SYNC_STAGES=2, in_data=32'hDEADBEEF, raise in_send.
  - Required: out_ack=1 on the 3rd clk edge. level=1, out_valid=1, out_data=32'hDEADBEEF.
  - Then drop in_send: out_ack=0 three edges later.
- Fill and backpressure:
  - Stimulus: DEPTH=4; four handshakes with data 1,2,3,4 and in_ready=0; then a 5th handshake with data 5.
  - Required: level=4; out_ack stays 0 for the 5th.
  - Then pulse in_ready one cycle: pops 1, the 5th is captured, out_ack rises, level returns to 4. Subsequent pops yield 2,3,4,5.
- Wrap and simultaneous push/pop: stream 10 words 0x10..0x19 with in_ready=1 continuously -> output order 0x10..0x19, level never exceeds 2, pointers wrap with no loss or duplication.
- Timeout: TIMEOUT=8, complete the ACK but hold in_send=1 -> err_timeout=1 after 8 cycles in ACKED; it stays 1 after in_send drops and the handshake completes; cleared only by rst=0.
- Reset mid-handshake: assert rst=0 while out_ack=1 with level=2 -> out_ack=0, level=0, out_valid=0 immediately, without waiting for a clk edge.
